// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single registered memory port.
// One transaction in flight; round-robin on ties; response timeout aborts with err_o.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  output logic [31:0] fetch_rdata_o,
  output logic        fetch_ack_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_wstrb_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ack_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ready_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYC);

  state_t     state;
  logic       last_grant;  // 1 = data was granted last
  logic       owner;       // 1 = data owns the transaction in flight
  logic [7:0] cnt;
  logic       fetch_elig, data_elig, pick_data;
  logic [7:0] cnt_nxt;

  // A requester being acked this cycle is still holding req; don't regrant it.
  assign fetch_elig = fetch_req_i & ~fetch_ack_o;
  assign data_elig  = data_req_i  & ~data_ack_o;
  assign pick_data  = data_elig & (~fetch_elig | ~last_grant);
  assign cnt_nxt    = cnt + 8'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      owner         <= 1'b0;
      cnt           <= '0;
      fetch_rdata_o <= '0;
      fetch_ack_o   <= 1'b0;
      data_rdata_o  <= '0;
      data_ack_o    <= 1'b0;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      mem_wstrb_o   <= '0;
      err_o         <= 1'b0;
    end else begin
      fetch_ack_o <= 1'b0;
      data_ack_o  <= 1'b0;
      err_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_elig | data_elig) begin
            owner      <= pick_data;
            last_grant <= pick_data;
            mem_req_o  <= 1'b1;
            state      <= ISSUE;
            if (pick_data) begin
              mem_we_o    <= data_we_i;
              mem_addr_o  <= data_addr_i;
              mem_wdata_o <= data_wdata_i;
              mem_wstrb_o <= data_wstrb_i;
            end else begin
              mem_we_o    <= 1'b0;
              mem_addr_o  <= fetch_addr_i;
              mem_wdata_o <= '0;
              mem_wstrb_o <= '0;
            end
          end
        end
        ISSUE: begin
          if (mem_ready_i) begin
            mem_req_o <= 1'b0;
            cnt       <= '0;
            state     <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (mem_rvalid_i || cnt_nxt == TO_LIMIT) begin
            // Timeout returns zero data with err_o alongside the ack.
            if (owner) begin
              data_ack_o   <= 1'b1;
              data_rdata_o <= mem_rvalid_i ? mem_rdata_i : 32'h0;
            end else begin
              fetch_ack_o   <= 1'b1;
              fetch_rdata_o <= mem_rvalid_i ? mem_rdata_i : 32'h0;
            end
            err_o <= ~mem_rvalid_i;
            state <= IDLE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester drivers, a memory responder
// keyed on address, and an ack monitor popping expected results.
module tb_mem_port_arbiter;

  localparam logic [31:0] NORSP = 32'h0000_3000;

  logic        clk_i, rst_i;
  logic        fetch_req_i, fetch_ack_o;
  logic [31:0] fetch_addr_i, fetch_rdata_o;
  logic        data_req_i, data_we_i, data_ack_o;
  logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic [3:0]  data_wstrb_i;
  logic        mem_req_o, mem_we_o, mem_ready_i, mem_rvalid_i, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [3:0]  mem_wstrb_o;

  mem_port_arbiter #(.TIMEOUT_CYC(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .fetch_req_i(fetch_req_i), .fetch_addr_i(fetch_addr_i),
    .fetch_rdata_o(fetch_rdata_o), .fetch_ack_o(fetch_ack_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_wstrb_i(data_wstrb_i),
    .data_rdata_o(data_rdata_o), .data_ack_o(data_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_ready_i(mem_ready_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  typedef struct {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} djob_t;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;

  logic [31:0] fq[$];
  djob_t       dq[$];
  exp_t        exp_f[$], exp_d[$];
  int          ack_log[$];

  int n_chk = 0, n_err = 0;
  int cyc = 0, f_start = 0, f_ack_cyc = 0, d_ack_cyc = 0;
  int n_acc = 0, acc_cyc = 0, n_req_cyc = 0;
  logic        f_acked = 0, d_acked = 0, f_kill = 0;
  logic        acc_we;
  logic [31:0] acc_addr, acc_wdata;
  logic [3:0]  acc_wstrb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
  endfunction

  function automatic int rsp_lat(input logic [31:0] a);
    return (a == 32'h400) ? 1 : int'(a[3:2]);
  endfunction

  task automatic push_fetch(input logic [31:0] a, input logic e);
    exp_t x;
    x.rdata = e ? 32'h0 : mem_model(a);
    x.err   = e;
    fq.push_back(a);
    exp_f.push_back(x);
  endtask

  task automatic push_data(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic e);
    djob_t j;
    exp_t  x;
    j.we = we; j.addr = a; j.wdata = wd; j.wstrb = ws;
    x.rdata = e ? 32'h0 : mem_model(a);
    x.err   = e;
    dq.push_back(j);
    exp_d.push_back(x);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((fq.size() + dq.size() + exp_f.size() + exp_d.size()) != 0 || fetch_req_i || data_req_i) begin
      @(negedge clk_i);
      k++;
      if (k > 300) begin
        chk(tag, 32'(exp_f.size() + exp_d.size()), 32'h0);
        break;
      end
    end
  endtask

  task automatic wait_acc(input int a0);
    int k;
    k = 0;
    while (n_acc == a0) begin
      @(negedge clk_i);
      k++;
      if (k > 100) begin
        chk("acc_wait", 32'(mem_req_o & mem_ready_i), 32'h1);
        break;
      end
    end
  endtask

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  // Requester drivers: hold req+payload until ack, then take the next job.
  initial begin : fdrv
    int w;
    fetch_req_i = 0; fetch_addr_i = 0; w = 0;
    forever begin
      @(posedge clk_i); #1;
      if (fetch_req_i && (f_acked || f_kill)) begin
        fetch_req_i = 0;
        f_acked = 0;
      end
      if (!fetch_req_i && fq.size() > 0 && !f_kill && !rst_i) begin
        fetch_addr_i = fq.pop_front();
        fetch_req_i  = 1;
        f_start = cyc;
        w = 0;
      end else if (fetch_req_i) begin
        w++;
        if (w > 60) begin
          chk("fetch_ack_wait", 32'(fetch_ack_o), 32'h1);
          fetch_req_i = 0;
        end
      end
    end
  end

  initial begin : ddrv
    int w;
    djob_t j;
    data_req_i = 0; data_we_i = 0; data_addr_i = 0; data_wdata_i = 0; data_wstrb_i = 0; w = 0;
    forever begin
      @(posedge clk_i); #1;
      if (data_req_i && d_acked) begin
        data_req_i = 0;
        d_acked = 0;
      end
      if (!data_req_i && dq.size() > 0 && !rst_i) begin
        j = dq.pop_front();
        data_we_i = j.we; data_addr_i = j.addr; data_wdata_i = j.wdata; data_wstrb_i = j.wstrb;
        data_req_i = 1;
        w = 0;
      end else if (data_req_i) begin
        w++;
        if (w > 60) begin
          chk("data_ack_wait", 32'(data_ack_o), 32'h1);
          data_req_i = 0;
        end
      end
    end
  end

  // Memory responder: ready stalls for 0x2000, no response for NORSP.
  initial begin : resp
    logic acc, pend, inreq;
    int rcnt, pcnt;
    logic [31:0] pdata, s_addr, s_wdata;
    logic s_we;
    logic [3:0] s_wstrb;
    mem_ready_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    acc = 0; pend = 0; inreq = 0; rcnt = 0; pcnt = 0; pdata = 0;
    s_addr = 0; s_wdata = 0; s_we = 0; s_wstrb = 0;
    forever begin
      @(posedge clk_i); #1;
      mem_rvalid_i = 0;
      mem_rdata_i  = $urandom;
      if (acc) begin
        mem_ready_i = 0;
        inreq = 0;
        if (acc_addr != NORSP) begin
          pend = 1;
          pcnt = rsp_lat(acc_addr);
          pdata = mem_model(acc_addr);
        end
      end
      if (pend) begin
        if (pcnt == 0) begin
          mem_rvalid_i = 1;
          mem_rdata_i  = pdata;
          pend = 0;
        end else pcnt--;
      end
      if (!mem_req_o) inreq = 0;
      else if (!inreq) begin
        inreq = 1;
        rcnt = (mem_addr_o == 32'h2000) ? 4 : 0;
        s_addr = mem_addr_o; s_wdata = mem_wdata_o; s_we = mem_we_o; s_wstrb = mem_wstrb_o;
      end
      if (inreq) begin
        mem_ready_i = (rcnt == 0);
        if (rcnt > 0) rcnt--;
      end else mem_ready_i = 0;
      @(negedge clk_i);
      if (mem_req_o) n_req_cyc++;
      if (inreq) begin
        chk("hold_req", 32'(mem_req_o), 32'h1);
        chk("hold_addr", mem_addr_o, s_addr);
        chk("hold_wdata", mem_wdata_o, s_wdata);
        chk("hold_ctl", {27'h0, mem_we_o, mem_wstrb_o}, {27'h0, s_we, s_wstrb});
      end
      acc = mem_req_o && mem_ready_i;
      if (acc) begin
        acc_addr = mem_addr_o; acc_we = mem_we_o; acc_wdata = mem_wdata_o; acc_wstrb = mem_wstrb_o;
        acc_cyc = cyc;
        n_acc++;
      end
    end
  end

  // Ack monitor: every ack pops the owning requester's expected result.
  initial forever begin
    exp_t e;
    @(negedge clk_i);
    if (fetch_ack_o || data_ack_o)
      chk("one_ack", 32'(fetch_ack_o & data_ack_o), 32'h0);
    else if (err_o)
      chk("err_alone", 32'(err_o), 32'h0);
    if (fetch_ack_o) begin
      if (exp_f.size() == 0) chk("fetch_unexp_ack", 32'(fetch_ack_o), 32'h0);
      else begin
        e = exp_f.pop_front();
        chk("fetch_rdata", fetch_rdata_o, e.rdata);
        chk("fetch_err", 32'(err_o), 32'(e.err));
      end
      ack_log.push_back(0);
      f_ack_cyc = cyc;
      f_acked = 1;
    end
    if (data_ack_o) begin
      if (exp_d.size() == 0) chk("data_unexp_ack", 32'(data_ack_o), 32'h0);
      else begin
        e = exp_d.pop_front();
        chk("data_rdata", data_rdata_o, e.rdata);
        chk("data_err", 32'(err_o), 32'(e.err));
      end
      ack_log.push_back(1);
      d_ack_cyc = cyc;
      d_acked = 1;
    end
  end

  initial begin
    int n0, a0, r0, ta;
    rst_i = 1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_mem_req", 32'(mem_req_o), 32'h0);
    chk("rst_acks", {29'h0, fetch_ack_o, data_ack_o, err_o}, 32'h0);
    chk("rst_fetch_rdata", fetch_rdata_o, 32'h0);
    chk("rst_data_rdata", data_rdata_o, 32'h0);
    rst_i = 0;

    // single fetch, minimum latency
    r0 = n_req_cyc;
    push_fetch(32'h100, 0);
    wait_drain("t1_drain");
    chk("t1_latency", 32'(f_ack_cyc - f_start), 32'd3);
    chk("t1_req_cycles", 32'(n_req_cyc - r0), 32'd1);
    chk("t1_addr", acc_addr, 32'h100);
    chk("t1_fetch_payload", {27'h0, acc_we, acc_wstrb}, 32'h0);
    chk("t1_fetch_wdata", acc_wdata, 32'h0);

    // both requesting out of reset: fetch wins first tie, then alternate
    @(negedge clk_i);
    rst_i = 1;
    n0 = ack_log.size();
    push_fetch(32'h10, 0);
    push_fetch(32'h14, 0);
    push_data(0, 32'h800, 32'h0, 4'h0, 0);
    push_data(0, 32'h804, 32'h0, 4'h0, 0);
    @(negedge clk_i);
    rst_i = 0;
    wait_drain("t2_drain");
    chk("t2_ack_count", 32'(ack_log.size() - n0), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_order", 32'(ack_log[n0 + i]), 32'(i % 2));

    // store with ready held low 4 cycles
    r0 = n_req_cyc;
    push_data(1, 32'h2000, 32'h12345678, 4'b0011, 0);
    wait_drain("t3_drain");
    chk("t3_req_cycles", 32'(n_req_cyc - r0), 32'd5);
    chk("t3_addr", acc_addr, 32'h2000);
    chk("t3_wdata", acc_wdata, 32'h12345678);
    chk("t3_ctl", {27'h0, acc_we, acc_wstrb}, {27'h0, 1'b1, 4'b0011});

    // timeout with a fetch queued behind it
    a0 = n_acc;
    push_data(0, NORSP, 32'h0, 4'h0, 1);
    wait_acc(a0);
    ta = acc_cyc;
    push_fetch(32'h20, 0);
    wait_drain("t4_drain");
    chk("t4_timeout_lat", 32'((d_ack_cyc - ta) >= 9 && (d_ack_cyc - ta) <= 10), 32'h1);
    chk("t4_next_granted", 32'(f_ack_cyc > d_ack_cyc), 32'h1);

    // reset during WAIT_RESP; response lands in the cycle after reset
    a0 = n_acc;
    push_fetch(32'h400, 0);
    wait_acc(a0);
    f_kill = 1;
    @(posedge clk_i); #1;
    rst_i = 1;
    exp_f.delete();
    @(posedge clk_i); #1;
    rst_i = 0;
    @(negedge clk_i);
    chk("t5_fetch_rdata", fetch_rdata_o, 32'h0);
    chk("t5_data_rdata", data_rdata_o, 32'h0);
    chk("t5_outs", {29'h0, mem_req_o, fetch_ack_o, err_o}, 32'h0);
    repeat (3) begin
      @(negedge clk_i);
      chk("t5_no_ack", 32'(fetch_ack_o | data_ack_o), 32'h0);
    end
    f_kill = 0;
    push_fetch(32'h104, 0);
    wait_drain("t5_drain");
    chk("t5_fresh_rdata", fetch_rdata_o, mem_model(32'h104));

    repeat (3) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
